// File: rtl/mc_sched_ctrl.sv
// mc_sched_ctrl: per-mode schedule bound table with period-boundary-aligned mode switching
module mc_sched_ctrl #(
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [13:0]       config_addr,
  input  logic              config_en,
  input  logic              config_wr,
  input  logic [31:0]       config_wdata,
  input  logic              sel,
  input  logic              period_boundary,
  output logic [31:0]       config_slv_rdata,
  output logic              config_slv_error,
  output logic [7:0]        stbl_min,
  output logic [7:0]        stbl_maxp1,
  output logic [MODE_W-1:0] mode_cur,
  output logic              mc_busy,
  output logic              mc_done
);
  localparam int N = 1 << MODE_W;
  typedef enum logic [1:0] {IDLE, ARM, COMMIT} state_t;
  state_t            state;
  logic [7:0]        tmin [N];
  logic [7:0]        tmax [N];
  logic [7:0]        sh_min, sh_max;
  logic [MODE_W-1:0] target;
  logic [10:0]       a;
  logic [MODE_W-1:0] idx, wmode;
  logic              acc, is_mode, is_tbl, err, mw, tw;
  logic [31:0]       rd;
  logic              unused_bits;
  assign unused_bits = ^{config_addr[13:11], config_wdata[31:16]};
  assign a       = config_addr[10:0];
  assign idx     = a[MODE_W-1:0];
  assign wmode   = config_wdata[MODE_W-1:0];
  assign acc     = sel & config_en;
  assign is_mode = a == 11'h000;
  assign is_tbl  = a >= 11'h010 && a < 11'(16 + N);
  // a busy change locks both the request register and the entry it is committing
  assign err = acc & (!(is_mode | is_tbl) | config_wr & (is_mode & mc_busy |
               is_tbl & (config_wdata[15:8] <= config_wdata[7:0] | mc_busy & idx == target)));
  assign mw = acc & config_wr & is_mode & !err;
  assign tw = acc & config_wr & is_tbl & !err;
  always_comb rd = is_mode ? {mc_busy, 11'b0, 4'(target), 12'b0, 4'(mode_cur)}
                           : {16'b0, tmax[idx], tmin[idx]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      for (int i = 0; i < N; i++) begin
        tmin[i] <= 8'h00;
        tmax[i] <= 8'h01;
      end
      sh_min           <= 8'h00;
      sh_max           <= 8'h01;
      target           <= '0;
      stbl_min         <= 8'h00;
      stbl_maxp1       <= 8'h01;
      mode_cur         <= '0;
      mc_busy          <= 1'b0;
      mc_done          <= 1'b0;
      config_slv_rdata <= '0;
      config_slv_error <= 1'b0;
    end else begin
      config_slv_error <= err;
      config_slv_rdata <= acc & !config_wr & !err ? rd : '0;
      mc_done          <= 1'b0;
      if (tw) begin
        tmin[idx] <= config_wdata[7:0];
        tmax[idx] <= config_wdata[15:8];
      end
      case (state)
        IDLE: if (mw) begin
          if (wmode != mode_cur) begin
            target  <= wmode;
            sh_min  <= tmin[wmode];
            sh_max  <= tmax[wmode];
            mc_busy <= 1'b1;
            state   <= ARM;
          end else mc_done <= 1'b1;
        end
        // min moves first so the wrap in progress still ends on the old maxp1
        ARM: if (period_boundary) begin
          stbl_min <= sh_min;
          state    <= COMMIT;
        end
        COMMIT: if (period_boundary) begin
          stbl_maxp1 <= sh_max;
          mode_cur   <= target;
          mc_done    <= 1'b1;
          mc_busy    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
